// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch decode constants and the funct3 -> taken/illegal rules
// used by the execute-stage branch resolve unit.
package branch_resolve_unit_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] FNC_BEQ     = 3'b000;
    localparam logic [2:0] FNC_BNE     = 3'b001;
    localparam logic [2:0] FNC_BR_ILL0 = 3'b010;
    localparam logic [2:0] FNC_BR_ILL1 = 3'b011;
    localparam logic [2:0] FNC_BLT     = 3'b100;
    localparam logic [2:0] FNC_BGE     = 3'b101;
    localparam logic [2:0] FNC_BLTU    = 3'b110;
    localparam logic [2:0] FNC_BGEU    = 3'b111;

    localparam logic BrUn_SIGNED   = 1'b1;
    localparam logic BrUn_UNSIGNED = 1'b0;

    // Signedness comes from BrUn, so the signed and unsigned forms share one rule.
    function automatic logic br_taken(input logic [2:0] funct3, input logic eq,
                                      input logic lt);
        logic t;
        case (funct3)
            FNC_BEQ:                t = eq;
            FNC_BNE:                t = ~eq;
            FNC_BLT, FNC_BLTU:      t = lt;
            FNC_BGE, FNC_BGEU:      t = ~lt;
            FNC_BR_ILL0, FNC_BR_ILL1: t = 1'b0;
            default:                t = 1'b0;
        endcase
        return t;
    endfunction

    function automatic logic br_illegal(input logic [2:0] funct3);
        return (funct3 == FNC_BR_ILL0) || (funct3 == FNC_BR_ILL1);
    endfunction

endpackage

// File: rtl/br_comparator.sv
// Combinational operand comparator producing BrEq and BrLt under the BrUn mode.
module br_comparator
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            BrUn,
    output logic            BrEq,
    output logic            BrLt
);

    always_comb begin
        BrEq = (a == b);
        BrLt = 1'b0;
        unique case (BrUn)
            BrUn_SIGNED:   BrLt = ($signed(a) < $signed(b));
            BrUn_UNSIGNED: BrLt = (a < b);
            default:       BrLt = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: condition evaluation, registered PC redirect,
// wrong-path shadow kill and branch statistics. Static not-taken prediction.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             stall,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1_data,
    input  logic [XLEN-1:0]  rs2_data,
    input  logic             BrUn,
    output logic             BrEq,
    output logic             BrLt,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             kill,
    output logic             illegal_br,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] taken_count
);

    logic             redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
    logic             illegal_br_q, illegal_br_d;
    logic             shadow_q, shadow_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;

    logic       fire;
    logic       eval;
    logic       taken;
    logic [2:0] funct3;
    logic       unused_inst;

    assign funct3      = inst[14:12];
    assign unused_inst = ^{inst[31:15], inst[11:7]};

    br_comparator #(
        .XLEN (XLEN)
    ) u_br_comparator (
        .a    (rs1_data),
        .b    (rs2_data),
        .BrUn (BrUn),
        .BrEq (BrEq),
        .BrLt (BrLt)
    );

    always_comb begin
        fire  = in_valid & ~stall;
        eval  = fire & ~shadow_q & (inst[6:0] == OPC_BRANCH);
        taken = eval & br_taken(funct3, BrEq, BrLt);

        redirect_valid_d = taken;
        redirect_pc_d    = taken ? (pc + imm) : redirect_pc_q;
        illegal_br_d     = eval & br_illegal(funct3);

        // The first unstalled valid instruction after a taken branch is the
        // wrong-path one; consuming it ends the shadow.
        shadow_d = shadow_q ? ~fire : taken;

        br_count_d    = br_count_q + {{(CNT_W-1){1'b0}}, eval};
        taken_count_d = taken_count_q + {{(CNT_W-1){1'b0}}, taken};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            illegal_br_q     <= 1'b0;
            shadow_q         <= 1'b0;
            br_count_q       <= '0;
            taken_count_q    <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            illegal_br_q     <= illegal_br_d;
            shadow_q         <= shadow_d;
            br_count_q       <= br_count_d;
            taken_count_q    <= taken_count_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign illegal_br     = illegal_br_q;
    assign kill           = shadow_q & in_valid;
    assign br_count       = br_count_q;
    assign taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a cycle-level reference model.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             stall;
    logic [31:0]      inst;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic             BrUn;
    logic             BrEq;
    logic             BrLt;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             kill;
    logic             illegal_br;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] taken_count;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .stall          (stall),
        .inst           (inst),
        .pc             (pc),
        .imm            (imm),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .BrUn           (BrUn),
        .BrEq           (BrEq),
        .BrLt           (BrLt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .kill           (kill),
        .illegal_br     (illegal_br),
        .br_count       (br_count),
        .taken_count    (taken_count)
    );

    // Reference model state: what the outputs must be after each edge.
    bit          m_shadow = 1'b0;
    bit          m_rv     = 1'b0;
    logic [31:0] m_rpc    = '0;
    bit          m_ill    = 1'b0;
    logic [31:0] m_br     = '0;
    logic [31:0] m_tk     = '0;

    // Signed order equals unsigned order once the sign bit is flipped.
    function automatic bit ref_lt(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        logic [31:0] bias;
        bias = sgn ? 32'h8000_0000 : 32'h0;
        return (a ^ bias) < (b ^ bias);
    endfunction

    function automatic bit ref_taken(input logic [2:0] f, input bit eq, input bit lt);
        case (f)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] br(input logic [2:0] f);
        return {17'h0, f, 5'h0, 7'h63};
    endfunction

    always @(posedge clk or posedge rst) begin : model
        bit fire;
        bit t;
        if (rst) begin
            m_shadow = 1'b0;
            m_rv     = 1'b0;
            m_rpc    = '0;
            m_ill    = 1'b0;
            m_br     = '0;
            m_tk     = '0;
        end else begin
            fire  = in_valid && !stall;
            m_rv  = 1'b0;
            m_ill = 1'b0;
            if (m_shadow) begin
                if (fire) m_shadow = 1'b0;
            end else if (fire && inst[6:0] == 7'h63) begin
                m_br  = m_br + 1;
                m_ill = (inst[14:13] == 2'b01);
                t = ref_taken(inst[14:12], rs1_data == rs2_data, ref_lt(rs1_data, rs2_data, BrUn));
                if (t) begin
                    m_tk     = m_tk + 1;
                    m_rv     = 1'b1;
                    m_rpc    = pc + imm;
                    m_shadow = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        if (rst) return;
        check("BrEq", 64'(BrEq), 64'(rs1_data == rs2_data));
        check("BrLt", 64'(BrLt), 64'(ref_lt(rs1_data, rs2_data, BrUn)));
        check("kill", 64'(kill), 64'(m_shadow && in_valid));
        check("redirect_valid", 64'(redirect_valid), 64'(m_rv));
        check("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
        check("illegal_br", 64'(illegal_br), 64'(m_ill));
        check("br_count", 64'(br_count), 64'(m_br));
        check("taken_count", 64'(taken_count), 64'(m_tk));
    endtask

    // One cycle: inputs settle just after the edge, outputs are compared mid-cycle.
    task automatic drive(input logic v, input logic st, input logic [31:0] ins,
                         input logic [31:0] p, input logic [31:0] im,
                         input logic [31:0] a, input logic [31:0] b, input logic un);
        @(posedge clk);
        #1;
        in_valid = v;
        stall    = st;
        inst     = ins;
        pc       = p;
        imm      = im;
        rs1_data = a;
        rs2_data = b;
        BrUn     = un;
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        stall    = 1'b0;
        inst     = NOP;
        pc       = '0;
        imm      = '0;
        rs1_data = '0;
        rs2_data = '0;
        BrUn     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
        check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        check("rst_illegal_br", 64'(illegal_br), 64'd0);
        check("rst_br_count", 64'(br_count), 64'd0);
        check("rst_taken_count", 64'(taken_count), 64'd0);
        check("rst_kill", 64'(kill), 64'd0);
        rst = 1'b0;

        // Signedness of the comparator
        drive(1'b0, 1'b0, NOP, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 1'b1);
        check("t1_signed_lt", 64'(BrLt), 64'd1);
        check("t1_signed_eq", 64'(BrEq), 64'd0);
        drive(1'b0, 1'b0, NOP, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        check("t1_unsigned_lt", 64'(BrLt), 64'd0);
        drive(1'b0, 1'b1, NOP, 32'h0, 32'h0, 32'h1234, 32'h1234, 1'b1);
        check("t1_eq", 64'(BrEq), 64'd1);

        // BLT taken, one-cycle redirect
        drive(1'b1, 1'b0, br(3'b100), 32'h100, 32'h20, 32'hFFFF_FFFB, 32'h3, 1'b1);
        check("t2_no_early_redirect", 64'(redirect_valid), 64'd0);
        idle();
        check("t2_redirect_valid", 64'(redirect_valid), 64'd1);
        check("t2_redirect_pc", 64'(redirect_pc), 64'h120);
        check("t2_taken_count", 64'(taken_count), 64'd1);
        check("t2_br_count", 64'(br_count), 64'd1);
        idle();
        check("t2_pulse_ends", 64'(redirect_valid), 64'd0);
        check("t2_pc_holds", 64'(redirect_pc), 64'h120);
        drive(1'b1, 1'b0, NOP, 32'h104, 32'h0, 32'h0, 32'h0, 1'b0);
        check("t2_shadow_kill", 64'(kill), 64'd1);

        // Shadow kill of a would-be-taken BNE
        drive(1'b1, 1'b0, br(3'b000), 32'h200, 32'h40, 32'h7, 32'h7, 1'b0);
        drive(1'b1, 1'b0, br(3'b001), 32'h204, 32'h80, 32'h1, 32'h2, 1'b0);
        check("t3_kill", 64'(kill), 64'd1);
        check("t3_redirect_pc", 64'(redirect_pc), 64'h240);
        idle();
        check("t3_no_second_redirect", 64'(redirect_valid), 64'd0);
        check("t3_br_count", 64'(br_count), 64'd2);

        // Stall held across the shadow
        drive(1'b1, 1'b0, br(3'b101), 32'h300, 32'hFFFF_FFFC, 32'h5, 32'h5, 1'b1);
        drive(1'b1, 1'b1, NOP, 32'h304, 32'h0, 32'h0, 32'h0, 1'b0);
        check("t4_rv_first", 64'(redirect_valid), 64'd1);
        check("t4_rpc", 64'(redirect_pc), 64'h2FC);
        check("t4_kill1", 64'(kill), 64'd1);
        drive(1'b1, 1'b1, NOP, 32'h304, 32'h0, 32'h0, 32'h0, 1'b0);
        check("t4_rv_second", 64'(redirect_valid), 64'd0);
        check("t4_kill2", 64'(kill), 64'd1);
        drive(1'b1, 1'b1, NOP, 32'h304, 32'h0, 32'h0, 32'h0, 1'b0);
        check("t4_kill3", 64'(kill), 64'd1);
        drive(1'b1, 1'b0, br(3'b000), 32'h304, 32'h8, 32'h9, 32'h9, 1'b0);
        check("t4_kill_unstalled", 64'(kill), 64'd1);
        drive(1'b1, 1'b0, br(3'b000), 32'h400, 32'h8, 32'h9, 32'h9, 1'b0);
        check("t4_shadow_cleared", 64'(kill), 64'd0);
        check("t4_killed_not_counted", 64'(br_count), 64'd3);
        drive(1'b1, 1'b0, NOP, 32'h404, 32'h0, 32'h0, 32'h0, 1'b0);
        check("t4_redirect_pc2", 64'(redirect_pc), 64'h408);

        // Illegal funct3 and not-taken unsigned compare
        drive(1'b1, 1'b0, br(3'b011), 32'h500, 32'h10, 32'h1, 32'h1, 1'b0);
        drive(1'b1, 1'b0, br(3'b110), 32'h504, 32'h10, 32'hFFFF_FFFF, 32'h1, 1'b0);
        check("t5_illegal_pulse", 64'(illegal_br), 64'd1);
        check("t5_no_redirect", 64'(redirect_valid), 64'd0);
        check("t5_br_count", 64'(br_count), 64'd5);
        check("t5_taken_count", 64'(taken_count), 64'd4);
        idle();
        check("t5_illegal_ends", 64'(illegal_br), 64'd0);
        check("t5_bltu_not_taken", 64'(redirect_valid), 64'd0);

        // Target wrap, stalled branch, non-branch opcode
        drive(1'b1, 1'b0, br(3'b111), 32'hFFFF_FFFC, 32'h8, 32'h2, 32'h1, 1'b0);
        drive(1'b1, 1'b0, NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        check("t7_wrap_pc", 64'(redirect_pc), 64'h4);
        drive(1'b1, 1'b1, br(3'b000), 32'h600, 32'h10, 32'h3, 32'h3, 1'b0);
        drive(1'b1, 1'b0, 32'h0000_0033, 32'h600, 32'h10, 32'h3, 32'h3, 1'b0);
        idle();
        check("t7_no_count", 64'(br_count), 64'd7);

        // Asynchronous reset in the middle of a redirect pulse
        drive(1'b1, 1'b0, br(3'b001), 32'h700, 32'h10, 32'h1, 32'h2, 1'b0);
        idle();
        check("t6_rv_before", 64'(redirect_valid), 64'd1);
        check("t6_tk_before", 64'(taken_count), 64'd6);
        #1 rst = 1'b1;
        #1;
        check("t6_rv_async", 64'(redirect_valid), 64'd0);
        check("t6_rpc_async", 64'(redirect_pc), 64'd0);
        check("t6_br_async", 64'(br_count), 64'd0);
        check("t6_tk_async", 64'(taken_count), 64'd0);
        check("t6_ill_async", 64'(illegal_br), 64'd0);
        #1 rst = 1'b0;
        drive(1'b1, 1'b0, br(3'b100), 32'h800, 32'h20, 32'h1, 32'h2, 1'b0);
        check("t6_no_shadow", 64'(kill), 64'd0);
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage consumer of the BrUn select. It compares rs1 and rs2 in signed or unsigned mode, as BrUn directs, and drives BrEq and BrLt.
- It evaluates the branch condition from funct3 and issues a registered one-cycle PC redirect on a taken branch.
- It kills the one wrong-path instruction that follows a taken branch and keeps branch and taken statistics counters.
- Prediction is static not-taken: every taken branch counts as a redirect.

Parameters:
- XLEN, 32, datapath width of the operands, PC and immediate.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  the execute stage holds a valid instruction.
- stall  in  1  pipeline stall; while it is high the unit evaluates nothing and its state holds.
- inst  in  32  instruction in the execute stage.
- pc  in  XLEN  PC of inst.
- imm  in  XLEN  sign-extended B-type immediate.
- rs1_data  in  XLEN  forwarded rs1 operand.
- rs2_data  in  XLEN  forwarded rs2 operand.
- BrUn  in  1  comparison mode: 0 = unsigned, 1 = signed.
- BrEq  out  1  combinational: rs1_data == rs2_data.
- BrLt  out  1  combinational: rs1_data < rs2_data under the BrUn mode.
- redirect_valid  out  1  registered one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  XLEN  registered target, pc+imm modulo 2^XLEN.
- kill  out  1  combinational: the current execute instruction is wrong-path and must not commit.
- illegal_br  out  1  registered one-cycle pulse for a branch opcode with funct3 010 or 011.
- br_count  out  CNT_W  number of branches evaluated.
- taken_count  out  CNT_W  number of branches taken.

Behaviour:
- BrEq and BrLt are evaluated every cycle, regardless of in_valid and stall.
- Evaluate condition: in_valid & ~stall & ~shadow & inst[6:0]==OPC_BRANCH.
- Taken rule by funct3:
  - BEQ (000): BrEq.
  - BNE (001): ~BrEq.
  - BLT (100) and BLTU (110): BrLt.
  - BGE (101) and BGEU (111): ~BrLt.
  - 010 and 011: never taken.
- The unit takes BrUn from its input and does not re-decode funct3 for signedness.
- Latency: evaluation in cycle N; redirect_valid, redirect_pc and illegal_br appear in cycle N+1.
- redirect_valid is high for exactly one cycle. In any cycle without a taken evaluation it returns to 0 on the next edge, including when stall is high.
- redirect_pc holds its last value when redirect_valid is 0.
- Shadow flag:
  - Set on the edge that ends a taken evaluation.
  - kill = shadow & in_valid.
  - Cleared on the first edge where in_valid & ~stall; that instruction is discarded and never evaluated or counted.
  - Holds across stalls and across in_valid=0 cycles.
  - A taken branch arriving while shadow is set is itself killed; there is no chained redirect.
- Counters:
  - br_count increments on every evaluation, including illegal funct3.
  - taken_count increments on taken evaluations.
  - Both wrap modulo 2^CNT_W.
- Reset (asynchronous, immediate): redirect_valid=0, redirect_pc=0, illegal_br=0, shadow=0, br_count=0, taken_count=0.
- Reset asserted mid-redirect truncates the pulse immediately.
- Non-branch opcodes never redirect, never count and never clear shadow unless they are the killed shadow instruction.
- Target wrap: pc=0xFFFFFFFC with imm=8 gives redirect_pc=0x00000004.

Decomposition:
- Shared headers:
  - OPC_BRANCH and the FNC_BEQ/BNE/BLT/BGE/BLTU/BGEU codes stay in Opcode.vh.
  - BrUn_SIGNED=1 and BrUn_UNSIGNED=0 stay in ControlLogicSel.vh.
  - Add FNC_BR_ILL0 (010) and FNC_BR_ILL1 (011) to Opcode.vh.
- One sub-module, br_comparator: purely combinational, (a, b, BrUn) -> (BrEq, BrLt). It is reused by any later forwarding or prediction logic.

Test Plan:
1. Signedness: BrUn=1, rs1=0xFFFFFFFF, rs2=0x00000001 -> BrLt=1, BrEq=0. BrUn=0 with the same operands -> BrLt=0.
2. BLT taken: pc=0x100, imm=0x20, rs1=-5, rs2=3, BrUn=1 -> next cycle redirect_valid=1 for one cycle, redirect_pc=0x120, taken_count=1, br_count=1.
3. Shadow kill: a taken BEQ followed by a valid BNE that would be taken -> kill=1 on the BNE, no second redirect, br_count=1.
4. Stall interaction: a taken branch, then stall held high for 3 cycles with in_valid=1 -> redirect_valid high only in the first cycle, kill high throughout, shadow clears on the first unstalled cycle.
5. Illegal funct3 011 on OPC_BRANCH -> illegal_br pulses once, no redirect, br_count+1, taken_count unchanged.
6. Asynchronous reset asserted mid-cycle while redirect_valid=1 and both counters are nonzero -> all outputs clear immediately, without waiting for a clk edge.
